// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and
// oversampling constants used by the receiver (and later the transmitter).
package uart_pkg;

    // Raw 3-bit state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } rx_state_e;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Oversampling: 16 sample ticks per bit, start bit qualified at tick 7
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for any input asynchronous to clk.
// RESET_VAL should match the idle level of the synchronised signal.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    // NOTE: non-blocking so each flop takes the pre-edge value of its source, giving a real 2-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, start + DBITS data +
// optional parity + 1 stop. One-cycle rx_done with word and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int         NBW       = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [3:0] MID       = 4'(MID_TICK);
    localparam logic [3:0] LAST      = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [NBW-1:0] NB_LAST = NBW'(DBITS - 1);

    logic rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk   (clk_100MHz),
        .rst_n (reset_n),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_e        state_q,      state_d;
    logic [3:0]       tick_q,       tick_d;
    logic [NBW-1:0]   nbits_q,      nbits_d;
    logic [DBITS-1:0] shift_q,      shift_d;
    logic             p_bad_q,      p_bad_d;
    logic [DBITS-1:0] data_q,       data_d;
    logic             rx_done_q,    rx_done_d;
    logic             frame_err_q,  frame_err_d;
    logic             parity_err_q, parity_err_d;

    // Next-state and next-output logic for the receive FSM
    // NOTE: every _d gets its hold value first, so no branch leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        nbits_d      = nbits_q;
        shift_d      = shift_q;
        p_bad_d      = p_bad_q;
        data_d       = data_q;
        rx_done_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        unique case (state_q)
            ST_IDLE: begin
                // Falling edge on the synchronised line starts a frame; no tick needed
                if (!rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end

            ST_START: begin
                if (sample_tick) begin
                    if (tick_q == MID) begin
                        // Still low at mid-bit: genuine start bit, else a glitch
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            tick_d  = '0;
                            nbits_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (sample_tick) begin
                    if (tick_q == LAST) begin
                        // One full bit after the previous centre: sample this bit's centre
                        shift_d = {rx_s, shift_q[DBITS-1:1]};
                        tick_d  = '0;
                        if (nbits_q == NB_LAST) begin
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            nbits_d = nbits_q + NBW'(1);
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (sample_tick) begin
                    if (tick_q == LAST) begin
                        // Parity over data plus parity bit: even wants 0, odd wants 1
                        p_bad_d = (PARITY == PAR_EVEN) ? (^{shift_q, rx_s}) : (~^{shift_q, rx_s});
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            ST_STOP: begin
                if (sample_tick) begin
                    if (tick_q == STOP_LAST) begin
                        // Stop-bit centre: publish the word and return to IDLE so the
                        // next start edge in the second half of the stop bit is caught
                        rx_done_d    = 1'b1;
                        data_d       = shift_q;
                        frame_err_d  = ~rx_s;
                        parity_err_d = (PARITY != PAR_NONE) ? p_bad_q : 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            nbits_q      <= '0;
            shift_q      <= '0;
            p_bad_q      <= 1'b0;
            data_q       <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            nbits_q      <= nbits_d;
            shift_q      <= shift_d;
            p_bad_q      <= p_bad_d;
            data_q       <= data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data_out   = data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: one instance without parity, one with even parity.
// Expected frames are queued as they are sent and popped on rx_done.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic [1:0] div = 2'd0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;

    logic [7:0] data_out0, data_out1;
    logic       rx_done0, rx_done1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int last_cyc0 = 0;
    int prev_cyc0 = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    uart_rx #(.DBITS(8), .SB_TICK(16), .PARITY(PAR_NONE)) dut0 (
        .clk_100MHz  (clk),
        .reset_n     (reset_n),
        .rx          (rx0),
        .sample_tick (sample_tick),
        .data_out    (data_out0),
        .rx_done     (rx_done0),
        .frame_err   (frame_err0),
        .parity_err  (parity_err0)
    );

    uart_rx #(.DBITS(8), .SB_TICK(16), .PARITY(PAR_EVEN)) dut1 (
        .clk_100MHz  (clk),
        .reset_n     (reset_n),
        .rx          (rx1),
        .sample_tick (sample_tick),
        .data_out    (data_out1),
        .rx_done     (rx_done1),
        .frame_err   (frame_err1),
        .parity_err  (parity_err1)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Baud generator stand-in: one sample_tick every 4 clocks
    always @(posedge clk) begin
        div         <= div + 2'd1;
        sample_tick <= (div == 2'd3);
        cyc         <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the no-parity instance
    always @(negedge clk) begin
        if (rx_done0) begin
            exp_t e;
            done_cnt0++;
            prev_cyc0 = last_cyc0;
            last_cyc0 = cyc;
            check("sb0_has_entry", 32'(sb0.size() > 0), 32'd1);
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                check("data0",       data_out0,   e.data);
                check("frame_err0",  frame_err0,  e.fe);
                check("parity_err0", parity_err0, e.pe);
            end
        end
    end

    // Scoreboard for the even-parity instance
    always @(negedge clk) begin
        if (rx_done1) begin
            exp_t e;
            done_cnt1++;
            check("sb1_has_entry", 32'(sb1.size() > 0), 32'd1);
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check("data1",       data_out1,   e.data);
                check("frame_err1",  frame_err1,  e.fe);
                check("parity_err1", parity_err1, e.pe);
            end
        end
    end

    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop (low stop is shortened
    // past its centre so the line is back high before a new start qualifies)
    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic par_v, input logic stop_v);
        drive_bit(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], BIT_CLKS);
        if (has_par) drive_bit(which, par_v, BIT_CLKS);
        if (stop_v) begin
            drive_bit(which, 1'b1, BIT_CLKS);
        end else begin
            drive_bit(which, 1'b0, 44);
            drive_bit(which, 1'b1, 20);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb0.size() == 0 && sb1.size() == 0) break;
            @(negedge clk);
        end
        check(tag, 32'(sb0.size() + sb1.size()), 32'd0);
    endtask

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int cnt_before;

        repeat (3) @(negedge clk);
        check("rst_data0",   data_out0,   8'h00);
        check("rst_done0",   rx_done0,    1'b0);
        check("rst_fe0",     frame_err0,  1'b0);
        check("rst_pe0",     parity_err0, 1'b0);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Basic frame
        sb0.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_a5", 200);

        // Glitch: low for 5 ticks then back high
        cnt_before = done_cnt0;
        drive_bit(0, 1'b0, 20);
        drive_bit(0, 1'b1, 2 * BIT_CLKS);
        check("glitch_state",  32'(dut0.state_q), 32'(ST_IDLE));
        check("glitch_nodone", done_cnt0, cnt_before);
        check("glitch_data",   data_out0, 8'hA5);

        sb0.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_3c", 200);

        // Framing error then recovery
        sb0.push_back('{8'h81, 1'b1, 1'b0});
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        wait_drain("drain_81", 200);
        sb0.push_back('{8'h55, 1'b0, 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_55", 200);

        // Even parity: correct bit, then wrong bit
        sb1.push_back('{8'h07, 1'b0, 1'b0});
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_par_ok", 200);
        sb1.push_back('{8'h07, 1'b0, 1'b1});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_par_bad", 200);

        // Back-to-back frames, no idle gap
        sb0.push_back('{8'h00, 1'b0, 1'b0});
        sb0.push_back('{8'hFF, 1'b0, 1'b0});
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_b2b", 200);
        check("b2b_spacing", last_cyc0 - prev_cyc0, 10 * BIT_CLKS);

        // Reset during data bit 3 of 0xC3
        cnt_before = done_cnt0;
        drive_bit(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'(8'hC3 >> i), BIT_CLKS);
        drive_bit(0, 1'b0, 30);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_data0", data_out0,   8'h00);
        check("mid_rst_done0", rx_done0,    1'b0);
        check("mid_rst_fe0",   frame_err0,  1'b0);
        check("mid_rst_pe1",   parity_err1, 1'b0);
        check("mid_rst_data1", data_out1,   8'h00);
        rx0 = 1'b1;
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("mid_rst_nodone", done_cnt0, cnt_before);

        sb0.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        wait_drain("drain_5a", 200);

        check("done_cnt0", done_cnt0, 7);
        check("done_cnt1", done_cnt1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It oversamples the serial rx line with the shared baud-rate generator's sample_tick (16 ticks per bit) and reassembles LSB-first frames into parallel words. Each frame is start + DBITS data + optional parity + 1 stop. It emits a one-cycle rx_done strobe with the word and error flags, for the RX FIFO / AXI-Lite register front end.

Parameters:
DBITS, 8, data bits per frame (legal 5..8)
SB_TICK, 16, sample ticks for the stop bit (1 stop bit = 16)
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
clk_100MHz  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx  in  1  serial input, asynchronous to clk_100MHz, idle high
sample_tick  in  1  one-clock strobe from baud generator, 16x bit rate
data_out  out  DBITS  last received word, held until next rx_done
rx_done  out  1  one-clock pulse: data_out/errors updated this cycle
frame_err  out  1  stop bit sampled low on the last frame
parity_err  out  1  parity mismatch on the last frame (always 0 when PARITY=0)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Reset_n low forces:
  - state = IDLE
  - tick, nbits, shift register = 0
  - synchroniser flops = 1
  - data_out = 0, rx_done = 0, frame_err = 0, parity_err = 0
- Reset mid-frame aborts the frame with no rx_done.
- Input sync: rx passes through 2 flops (reset to 1). The FSM uses only rx_s. Latency rx -> rx_s is 2 clocks.
- tick counter: 4 bits, increments only on sample_tick.
- nbits: $clog2(DBITS) bits.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_s == 0 -> START, tick = 0.
  - sample_tick is not required to leave IDLE.
- START (mid-bit qualification):
  - On sample_tick with tick == 7: if rx_s == 0 -> DATA, tick = 0, nbits = 0.
  - If rx_s == 1 at that point -> IDLE (glitch rejected, no rx_done, flags unchanged).
  - Otherwise tick++.
- DATA:
  - On sample_tick with tick == 15: shift = {rx_s, shift[DBITS-1:1]}, tick = 0.
  - If nbits == DBITS-1 -> PARITY when PARITY != 0, else STOP. Otherwise nbits++.
  - Otherwise tick++.
  - Every sample lands at bit centre.
- PARITY:
  - On sample_tick with tick == 15: capture p_bad, tick = 0, -> STOP.
  - Even: p_bad = ^{shift, rx_s}.
  - Odd: p_bad = ~^{shift, rx_s}.
- STOP:
  - On sample_tick with tick == SB_TICK-1, next clock:
    - rx_done = 1
    - data_out = shift
    - frame_err = ~rx_s
    - parity_err = p_bad (0 if PARITY=0)
    - state -> IDLE
  - Otherwise tick++.
- Outputs are registered: rx_done is high exactly one clock per accepted frame, and data_out, frame_err and parity_err change only in that clock.
- Back-to-back frames: STOP returns to IDLE at the stop-bit centre. A start edge arriving in the second half of the stop bit is caught with no frame loss.
- Break (rx held low): the frame completes with frame_err = 1. IDLE then re-enters START immediately. Successive frames are 0x00 with frame_err = 1 until rx returns high.
- sample_tick asserted in IDLE: ignored. rx_s toggling without ticks: no state advance except IDLE -> START.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (3-bit localparams IDLE..STOP)
  - PARITY encodings (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2)
  - OVERSAMPLE = 16, MID_TICK = 7
- uart_tx's states may move into the same package.
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value parameter. It is reused for any asynchronous input.

Test Plan:
- Basic frame (sample_tick every 4 clocks, PARITY=0): rx frame 0xA5 -> one rx_done pulse, data_out = 0xA5, frame_err = 0, parity_err = 0.
- Glitch rejection: rx low for 5 ticks then high -> no rx_done, state back to IDLE, data_out unchanged. A following frame 0x3C is then received correctly.
- Framing error: frame 0x81 with stop bit driven 0 -> rx_done, data_out = 0x81, frame_err = 1. The next good frame 0x55 clears frame_err to 0.
- Parity (PARITY=2 even): frame 0x07 with parity bit 1 -> parity_err = 0. Frame 0x07 with parity bit 0 -> parity_err = 1, data_out = 0x07.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two rx_done pulses exactly 10 bit-times apart, data_out 0x00 then 0xFF, no errors.
- Reset mid-frame: reset_n low during data bit 3 of 0xC3 -> all outputs 0, no rx_done. After release, frame 0x5A -> data_out = 0x5A.
